sram_probe_scanner: RTL and testbench
=====================================

// Module: sram_probe_scanner
// PURPOSE
//  Drives the per-way SRAM probe interface of the std cache subsystem bench.
//  Walks a range of dcache sets, issues one probe address per way, and captures
//  the returned two-half data lines. It then streams each (set, way, data) entry
//  out over a valid/ready port to the scoreboard for cache-content comparison.
// PARAMETERS
//  DCACHE_SET_ASSOC  8    ways probed in parallel (one addr/data lane per way)
//  DATA_WIDTH        64   width of one data half; a line is 2*DATA_WIDTH
//  NUM_WORDS         256  sets per SRAM; AW = $clog2(NUM_WORDS)
//  READ_LATENCY      1    cycles from probe_addr_o stable to probe_data_i valid (>=0)
// PORTS
//  clk_i          in   1                          clock
//  rst_ni         in   1                          async active-low reset
//  start_i        in   1                          pulse: begin scan (accepted only in IDLE)
//  abort_i        in   1                          terminate scan, return to IDLE
//  set_first_i    in   AW                         first set, sampled with start_i
//  set_last_i     in   AW                         last set inclusive, sampled with start_i
//  probe_addr_o   out  [ASSOC][AW]                probe address per way
//  probe_data_i   in   [ASSOC][2][DATA_WIDTH]     probed line per way
//  out_valid_o    out  1                          entry available
//  out_ready_i    in   1                          consumer accepts entry
//  out_set_o      out  AW                         set index of entry
//  out_way_o      out  $clog2(ASSOC)              way index of entry
//  out_data_o     out  [1:0][DATA_WIDTH]          line data of entry
//  busy_o         out  1                          high in any state except IDLE
//  done_o         out  1                          1-cycle pulse when last entry handed off
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; probe_addr_o all 0; way buffer cleared.
//  FSM: IDLE -start_i-> ISSUE -> WAIT -> DRAIN -> (ISSUE next set | DONE) -> IDLE.
//  ISSUE: drive cur_set on every way's probe_addr_o; load latency counter.
//  WAIT: hold addr READ_LATENCY cycles, then capture probe_data_i of all ways in one
//   cycle into the way buffer. With READ_LATENCY=0, capture happens in ISSUE and WAIT is skipped.
//  probe_addr_o holds cur_set from ISSUE until capture; it is otherwise unchanged.
//  DRAIN: present ways 0..ASSOC-1 in order; the way index advances only on valid&&ready.
//   Once asserted, valid and data stay stable until ready.
//  After way ASSOC-1 handshakes: if cur_set==set_last -> DONE, else cur_set++ and ISSUE.
//  Increment wraps NUM_WORDS-1 -> 0, so set_first>set_last scans through the wrap.
//   set_first==set_last scans exactly one set.
//  DONE: done_o=1 for one cycle, busy_o still 1; next cycle IDLE.
//  start_i while busy: ignored. start_i and abort_i both high in IDLE: abort_i wins, nothing starts.
//  abort_i in any busy state: next cycle IDLE, out_valid_o=0 (the only permitted valid
//   drop without handshake), no done_o pulse.
//  Reset asserted mid-scan: immediate return to reset values; no partial output afterwards.
//  Full throughput: one entry per cycle during DRAIN with ready held high.
//   Per-set overhead: 1 + READ_LATENCY cycles.
// CONFIGURATION
//  SRAM_PROBE_CHECKSUM_EN defined: add output checksum_o [2*DATA_WIDTH].
//   Cleared on accepted start_i; XOR-accumulates out_data_o on every handshake.
//   Stable from DONE until the next start. Reset value 0.
//  Undefined: no checksum_o port and no accumulator logic; all other behaviour identical.
// STRUCTURE
//  Package sram_probe_pkg: addr_t, line_t (logic [1:0][DATA_WIDTH-1:0]),
//   way_idx_t, state enum (IDLE, ISSUE, WAIT, DRAIN, DONE), parameterised by cache config.
//  Sub-module sram_probe_way_buf: ASSOC-entry line buffer.
//   Parallel load, indexed read, way counter with last-way flag.
//  FSM, set counter with wrap, and latency counter stay in the top module.
// TESTING
//  T1 first=0,last=0, LAT=1, ready=1 -> 8 entries way0..7 set0, data = SRAM model.
//   done_o pulses 1 cycle after the last handshake.
//  T2 first=254,last=1 (NUM_WORDS=256) -> sets 254,255,0,1 in order, 32 entries, no gaps.
//  T3 ready toggles 1,0,0,1 during DRAIN -> valid/set/way/data held while ready=0.
//   No entry is lost or duplicated.
//  T4 abort_i in WAIT of set 5 -> IDLE next cycle, valid=0, no done_o.
//   A following start then scans normally.
//  T5 rst_ni low mid-DRAIN -> all outputs 0 while in reset.
//   After release, busy_o=0 until start_i.
//  T6 (SRAM_PROBE_CHECKSUM_EN) all lines 0xA5..A5 except one 0xFF..FF, 1 set ->
//   checksum_o = 0xA5..A5 ^ 0xFF..FF (eight lines, pairs of 0xA5 cancel).

Source files
------------

// File: rtl/sram_probe_pkg.sv
// Shared cache-geometry constants and types for the SRAM probe scanner.
package sram_probe_pkg;

    localparam int unsigned DCACHE_SET_ASSOC = 8;
    localparam int unsigned DATA_WIDTH       = 64;
    localparam int unsigned NUM_WORDS        = 256;
    localparam int unsigned AW               = $clog2(NUM_WORDS);
    localparam int unsigned WW               = $clog2(DCACHE_SET_ASSOC);

    typedef logic [AW-1:0]                addr_t;
    typedef logic [1:0][DATA_WIDTH-1:0]   line_t;
    typedef logic [WW-1:0]                way_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain,
        StDone
    } state_e;

    // Set increment wraps NUM_WORDS-1 -> 0 through the natural AW-bit overflow.
    function automatic addr_t next_set(input addr_t s);
        return s + addr_t'(1);
    endfunction

endpackage

// File: rtl/sram_probe_scanner_way_buf.sv
// Per-way line buffer for the probe scanner: parallel load of all ways, indexed read
// through an internal way counter that restarts on every load.
module sram_probe_way_buf
    import sram_probe_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic                          adv_i,
    input  line_t [DCACHE_SET_ASSOC-1:0]  data_i,
    output line_t                         rd_data_o,
    output way_idx_t                      way_o,
    output logic                          last_o
);

    line_t [DCACHE_SET_ASSOC-1:0] lines_q;
    way_idx_t                     way_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lines_q <= '0;
            way_q   <= '0;
        end else if (load_i) begin
            lines_q <= data_i;
            way_q   <= '0;
        end else if (adv_i) begin
            way_q   <= way_q + way_idx_t'(1);
        end
    end

    assign rd_data_o = lines_q[way_q];
    assign way_o     = way_q;
    assign last_o    = (way_q == way_idx_t'(DCACHE_SET_ASSOC - 1));

endmodule

// File: rtl/sram_probe_scanner.sv
// Walks a dcache set range, probes every way in parallel and streams (set, way, line) entries.
// Optional macro SRAM_PROBE_CHECKSUM_EN adds checksum_o, an XOR of all streamed lines.
module sram_probe_scanner
    import sram_probe_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  addr_t                         set_first_i,
    input  addr_t                         set_last_i,
    output addr_t [DCACHE_SET_ASSOC-1:0]  probe_addr_o,
    input  line_t [DCACHE_SET_ASSOC-1:0]  probe_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output addr_t                         out_set_o,
    output way_idx_t                      out_way_o,
    output line_t                         out_data_o,
    output logic                          busy_o,
    output logic                          done_o
`ifdef SRAM_PROBE_CHECKSUM_EN
    ,
    output logic [2*DATA_WIDTH-1:0]       checksum_o
`endif
);

    localparam int unsigned LatW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LatW-1:0] LatInit = LatW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_e          state_q;
    addr_t           cur_set_q, last_set_q, probe_addr_q;
    logic [LatW-1:0] lat_q;
    logic            out_valid_q, busy_q, done_q;
    logic            start_acc, capture, hs, way_last;

    // Abort outranks both a capture and a handshake in the same cycle.
    always_comb begin
        start_acc = (state_q == StIdle) && start_i && !abort_i;
        capture   = !abort_i && (((state_q == StIssue) && (READ_LATENCY == 0)) ||
                                 ((state_q == StWait) && (lat_q == '0)));
        hs        = out_valid_q && out_ready_i && !abort_i;
    end

    sram_probe_way_buf u_way_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (capture),
        .adv_i     (hs),
        .data_i    (probe_data_i),
        .rd_data_o (out_data_o),
        .way_o     (out_way_o),
        .last_o    (way_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cur_set_q    <= '0;
            last_set_q   <= '0;
            probe_addr_q <= '0;
            lat_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_acc) begin
                            cur_set_q    <= set_first_i;
                            last_set_q   <= set_last_i;
                            probe_addr_q <= set_first_i;
                            busy_q       <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end
                    StIssue: begin
                        lat_q <= LatInit;
                        if (capture) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDrain;
                        end else begin
                            state_q     <= StWait;
                        end
                    end
                    StWait: begin
                        if (capture) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDrain;
                        end else begin
                            lat_q <= lat_q - LatW'(1);
                        end
                    end
                    StDrain: begin
                        if (hs && way_last) begin
                            out_valid_q <= 1'b0;
                            if (cur_set_q == last_set_q) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                cur_set_q    <= next_set(cur_set_q);
                                probe_addr_q <= next_set(cur_set_q);
                                state_q      <= StIssue;
                            end
                        end
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef SRAM_PROBE_CHECKSUM_EN
    logic [2*DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (start_acc) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q ^ out_data_o;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign probe_addr_o = {DCACHE_SET_ASSOC{probe_addr_q}};
    assign out_valid_o  = out_valid_q;
    assign out_set_o    = cur_set_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sram_probe_scanner.sv
// Directed bench for sram_probe_scanner: table of scan vectors plus abort/reset sequences.
// Build with SRAM_PROBE_CHECKSUM_EN defined to also exercise checksum_o.
module tb_sram_probe_scanner;
    import sram_probe_pkg::*;

    typedef logic [159:0] cv_t;
    typedef struct {
        addr_t first;
        addr_t last;
        int    nsets;
        bit    toggle;
    } vec_t;

    logic                         clk = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         start_i = 1'b0;
    logic                         abort_i = 1'b0;
    logic                         out_ready_i = 1'b1;
    addr_t                        set_first_i = '0;
    addr_t                        set_last_i = '0;
    addr_t [DCACHE_SET_ASSOC-1:0] probe_addr_o;
    line_t [DCACHE_SET_ASSOC-1:0] mem_q = '0;
    logic                         out_valid_o, busy_o, done_o;
    addr_t                        out_set_o;
    way_idx_t                     out_way_o;
    line_t                        out_data_o;
`ifdef SRAM_PROBE_CHECKSUM_EN
    logic [2*DATA_WIDTH-1:0]      checksum_o;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    bit          pat_mode = 1'b0;
    logic [127:0] acc;
    vec_t        vecs[4];
    bit          tog_pat[4];

    sram_probe_scanner #(
        .READ_LATENCY (1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .set_first_i  (set_first_i),
        .set_last_i   (set_last_i),
        .probe_addr_o (probe_addr_o),
        .probe_data_i (mem_q),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_set_o    (out_set_o),
        .out_way_o    (out_way_o),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef SRAM_PROBE_CHECKSUM_EN
        ,
        .checksum_o   (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic line_t model(input addr_t s, input int w);
        line_t l;
        if (pat_mode) begin
            l = (w == 3) ? {16{8'hFF}} : {16{8'hA5}};
        end else begin
            l[0] = {8'hC0, 8'(w), 8'hDE, s, 32'h0123_4567 ^ {24'h0, s}};
            l[1] = {8'hBE, 8'(w), 8'hEF, ~s, 32'h89AB_CDEF ^ {8'(w), 24'h0}};
        end
        return l;
    endfunction

    // One-cycle-latency SRAM per way.
    always @(posedge clk) begin
        for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
            mem_q[w] <= model(probe_addr_o[w], w);
        end
    end

    task automatic check(input string name, input cv_t act, input cv_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl"}, cv_t'({busy_o, out_valid_o, done_o, out_set_o, out_way_o}), '0);
        check({tag, "_data"}, cv_t'(out_data_o), '0);
        check({tag, "_addr"}, cv_t'(probe_addr_o), '0);
    endtask

    task automatic run_scan(input addr_t first, input addr_t last, input int nsets,
                            input bit toggle);
        int       total;
        int       got;
        int       cyc;
        int       first_hs;
        int       last_hs;
        int       ph;
        bit       held;
        bit       r;
        addr_t    es;
        way_idx_t ew;
        addr_t    hset;
        way_idx_t hway;
        line_t    hdata;
        total    = nsets * DCACHE_SET_ASSOC;
        got      = 0;
        cyc      = 0;
        first_hs = -1;
        last_hs  = -1;
        ph       = 0;
        held     = 1'b0;
        hset     = '0;
        hway     = '0;
        hdata    = '0;
        acc      = '0;
        @(negedge clk);
        set_first_i = first;
        set_last_i  = last;
        start_i     = 1'b1;
        @(negedge clk);
        check("busy_after_start", cv_t'(busy_o), cv_t'(1'b1));
        check("probe_addr_issue", cv_t'(probe_addr_o), cv_t'({DCACHE_SET_ASSOC{first}}));
        while (got < total && cyc < 2000) begin
            // A start pulse with a different range while busy must be ignored.
            start_i     = (cyc == 3);
            set_first_i = (cyc == 3) ? ~first : first;
            if (held) begin
                check("hold", cv_t'({out_valid_o, out_set_o, out_way_o, out_data_o}),
                      cv_t'({1'b1, hset, hway, hdata}));
            end
            r = toggle ? tog_pat[ph % 4] : 1'b1;
            if (out_valid_o) ph++;
            out_ready_i = r;
            if (out_valid_o && r) begin
                es = first + addr_t'(got / DCACHE_SET_ASSOC);
                ew = way_idx_t'(got % DCACHE_SET_ASSOC);
                check("entry", cv_t'({out_set_o, out_way_o, out_data_o}),
                      cv_t'({es, ew, model(es, got % DCACHE_SET_ASSOC)}));
                acc = acc ^ out_data_o;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                got++;
            end
            held  = out_valid_o && !r;
            hset  = out_set_o;
            hway  = out_way_o;
            hdata = out_data_o;
            @(negedge clk);
            cyc++;
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        check("entry_count", cv_t'(got), cv_t'(total));
        check("first_entry_latency", cv_t'(first_hs), cv_t'(2));
        check("done_pulse", cv_t'({done_o, busy_o, out_valid_o}), cv_t'(3'b110));
        if (!toggle) begin
            check("drain_span", cv_t'(last_hs - first_hs),
                  cv_t'(total - 1 + (nsets - 1) * 2));
        end
        @(negedge clk);
        check("idle_after_done", cv_t'({done_o, busy_o, out_valid_o}), '0);
`ifdef SRAM_PROBE_CHECKSUM_EN
        check("checksum", cv_t'(checksum_o), cv_t'(acc));
`endif
    endtask

    initial begin
        int wait_cyc;
        vecs[0] = '{first: 8'd0,   last: 8'd0,   nsets: 1, toggle: 1'b0};
        vecs[1] = '{first: 8'd254, last: 8'd1,   nsets: 4, toggle: 1'b0};
        vecs[2] = '{first: 8'd7,   last: 8'd7,   nsets: 1, toggle: 1'b1};
        vecs[3] = '{first: 8'd100, last: 8'd102, nsets: 3, toggle: 1'b1};
        tog_pat[0] = 1'b1;
        tog_pat[1] = 1'b0;
        tog_pat[2] = 1'b0;
        tog_pat[3] = 1'b1;

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_scan(vecs[i].first, vecs[i].last, vecs[i].nsets, vecs[i].toggle);
        end

        // Abort while waiting on the SRAM for set 5.
        @(negedge clk);
        set_first_i = 8'd5;
        set_last_i  = 8'd6;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_to_idle", cv_t'({busy_o, out_valid_o, done_o}), '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet", cv_t'({busy_o, out_valid_o, done_o}), '0);
        end

        // start and abort together in idle: nothing starts.
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_abort_idle", cv_t'(busy_o), '0);
        run_scan(8'd5, 8'd6, 2, 1'b0);

        // Reset asserted mid-drain.
        @(negedge clk);
        set_first_i = 8'd40;
        set_last_i  = 8'd41;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        wait_cyc    = 0;
        while (!out_valid_o && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("valid_before_reset", cv_t'(out_valid_o), cv_t'(1'b1));
        rst_ni = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        check_zero_outputs("held_reset");
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_quiet", cv_t'({busy_o, out_valid_o, done_o}), '0);
        end
        run_scan(8'd200, 8'd200, 1, 1'b0);

`ifdef SRAM_PROBE_CHECKSUM_EN
        pat_mode = 1'b1;
        run_scan(8'd30, 8'd30, 1, 1'b0);
        check("checksum_pattern", cv_t'(checksum_o), cv_t'({16{8'hA5}} ^ {16{8'hFF}}));
        repeat (3) @(negedge clk);
        check("checksum_stable", cv_t'(checksum_o), cv_t'({16{8'h5A}}));
        pat_mode = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
